// File: rtl/bit_serial_subtractor8.sv
// Bit-serial A - B - Bin, one bit per clock (LSB first) with a start/busy/done handshake.
// Optional status flags (Zero, Neg, Ovf) are built when SUB_STATUS_FLAGS_EN is defined.
module bit_serial_subtractor8 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
`ifdef SUB_STATUS_FLAGS_EN
  ,
  output logic             Zero,
  output logic             Neg,
  output logic             Ovf
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [WIDTH-1:0]   r_a_sr;
  logic [WIDTH-1:0]   r_b_sr;
  logic [WIDTH-2:0]   r_res_sr;
  logic               r_bw;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_diff;
  logic               r_bout;

  logic               w_ready;
  logic               w_accept;
  logic               w_last;
  logic               w_a;
  logic               w_b;
  logic               w_d;
  logic               w_bw_nxt;
  logic [WIDTH-1:0]   w_res_nxt;

`ifdef SUB_STATUS_FLAGS_EN
  logic               r_a_msb;
  logic               r_b_msb;
  logic               r_zero;
  logic               r_neg;
  logic               r_ovf;
`endif

  assign w_ready  = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_accept = start && w_ready;
  assign w_last   = (r_state == S_RUN) && (r_cnt == CNT_W'(WIDTH - 1));

  // Full-subtractor cell on the current LSBs and the borrow flip-flop
  assign w_a       = r_a_sr[0];
  assign w_b       = r_b_sr[0];
  assign w_d       = w_a ^ w_b ^ r_bw;
  assign w_bw_nxt  = (~w_a & w_b) | (~(w_a ^ w_b) & r_bw);
  // The final difference bit goes straight to Diff, so the shift register keeps WIDTH-1 bits
  assign w_res_nxt = {w_d, r_res_sr};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = start ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == S_RUN);
      r_done <= (w_state_nxt == S_DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_res_sr <= '0;
      r_bw     <= 1'b0;
      r_cnt    <= '0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
    end else if (w_accept) begin
      r_a_sr <= A;
      r_b_sr <= B;
      r_bw   <= Bin;
      r_cnt  <= '0;
    end else if (r_state == S_RUN) begin
      r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
      r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
      r_res_sr <= w_res_nxt[WIDTH-1:1];
      r_bw     <= w_bw_nxt;
      r_cnt    <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_diff <= w_res_nxt;
        r_bout <= w_bw_nxt;
      end
    end
  end

`ifdef SUB_STATUS_FLAGS_EN
  // Operand sign bits are kept for the signed-overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_zero  <= 1'b0;
      r_neg   <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a_msb <= A[WIDTH-1];
      r_b_msb <= B[WIDTH-1];
    end else if (w_last) begin
      r_zero <= (w_res_nxt == '0);
      r_neg  <= w_res_nxt[WIDTH-1];
      r_ovf  <= (r_a_msb != r_b_msb) && (w_res_nxt[WIDTH-1] != r_a_msb);
    end
  end

  assign Zero = r_zero;
  assign Neg  = r_neg;
  assign Ovf  = r_ovf;
`endif

  assign busy = r_busy;
  assign done = r_done;
  assign Diff = r_diff;
  assign Bout = r_bout;

endmodule
